// File: rtl/ct_f_spsram_param.sv
// Parametrised single-port SRAM for FPGA builds: byte-lane write mask, optional
// zero-initialisation sweep after reset, 1- or 2-cycle read latency and a read-valid strobe.
module ct_f_spsram_param #(
   parameter int ADDR_WIDTH = 13,
   parameter int DATA_WIDTH = 32,
   parameter int WRAP_SIZE  = 8,
   parameter int READ_LAT   = 1,
   parameter bit INIT_EN    = 1'b1
) (
   input  logic                  CLK,
   input  logic                  RSTN,
   input  logic                  CEN,
   input  logic                  GWEN,
   input  logic [ADDR_WIDTH-1:0] A,
   input  logic [DATA_WIDTH-1:0] D,
   input  logic [DATA_WIDTH-1:0] WEN,
   output logic [DATA_WIDTH-1:0] Q,
   output logic                  RVLD,
   output logic                  INIT_DONE
);

   localparam int DEPTH = 2 ** ADDR_WIDTH;
   localparam int LANES = DATA_WIDTH / WRAP_SIZE;
   localparam logic [ADDR_WIDTH-1:0] CNT_ONE = ADDR_WIDTH'(1);

   generate
      if (DATA_WIDTH % WRAP_SIZE != 0) begin : gen_bad_wrap
         $error("ct_f_spsram_param: DATA_WIDTH must be a multiple of WRAP_SIZE");
      end
      if (READ_LAT != 1 && READ_LAT != 2) begin : gen_bad_lat
         $error("ct_f_spsram_param: READ_LAT must be 1 or 2");
      end
   endgenerate

   typedef enum logic [1:0] {
      ST_INIT,
      ST_WAIT1,
      ST_READY
   } state_e;

   state_e                state_q, state_d;
   logic [ADDR_WIDTH-1:0] initCnt_q, initCnt_d;
   logic                  initWrite;
   logic                  initDone;

   always_ff @(posedge CLK or negedge RSTN) begin
      if (!RSTN) begin
         state_q   <= INIT_EN ? ST_INIT : ST_WAIT1;
         initCnt_q <= '0;
      end else begin
         state_q   <= state_d;
         initCnt_q <= initCnt_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      initCnt_d = initCnt_q;
      case (state_q)
         ST_INIT: begin
            initCnt_d = initCnt_q + CNT_ONE;
            if (&initCnt_q) begin
               state_d = ST_READY;
            end
         end
         ST_WAIT1: state_d = ST_READY;
         default:  state_d = ST_READY;
      endcase
   end

   always_comb begin
      initWrite = (state_q == ST_INIT);
      initDone  = (state_q == ST_READY);
   end

   // Port traffic is only honoured once the array is usable.
   logic                  access;
   logic                  wrAcc;
   logic                  rdAcc;
   logic [LANES-1:0]      laneWe;
   logic [ADDR_WIDTH-1:0] addrHold_q;
   logic [ADDR_WIDTH-1:0] effAddr;
   logic                  unusedWen;

   assign access    = initDone && !CEN;
   assign wrAcc     = access && !GWEN;
   assign rdAcc     = access && GWEN;
   assign effAddr   = CEN ? addrHold_q : A;
   assign unusedWen = ^WEN;

   always_comb begin
      laneWe = '0;
      for (int k = 0; k < LANES; k++) begin
         laneWe[k] = wrAcc && !WEN[(k+1)*WRAP_SIZE-1];
      end
   end

   always_ff @(posedge CLK or negedge RSTN) begin
      if (!RSTN) begin
         addrHold_q <= '0;
      end else if (access) begin
         addrHold_q <= A;
      end
   end

   logic [DATA_WIDTH-1:0] mem [DEPTH];
   logic [DATA_WIDTH-1:0] oldWord;
   logic [DATA_WIDTH-1:0] mergeWord;

   // Write-first: the merged word feeds both the array and the read stage.
   always_comb begin
      oldWord   = mem[effAddr];
      mergeWord = oldWord;
      for (int k = 0; k < LANES; k++) begin
         if (laneWe[k]) begin
            mergeWord[k*WRAP_SIZE +: WRAP_SIZE] = D[k*WRAP_SIZE +: WRAP_SIZE];
         end
      end
   end

   always_ff @(posedge CLK) begin
      if (initWrite) begin
         mem[initCnt_q] <= '0;
      end else if (wrAcc) begin
         mem[effAddr] <= mergeWord;
      end
   end

   logic [DATA_WIDTH-1:0] stage1_q;
   logic [DATA_WIDTH-1:0] stage2_q;
   logic                  rvld1_q;
   logic                  rvld2_q;

   always_ff @(posedge CLK or negedge RSTN) begin
      if (!RSTN) begin
         stage1_q <= '0;
         stage2_q <= '0;
         rvld1_q  <= 1'b0;
         rvld2_q  <= 1'b0;
      end else begin
         if (access) begin
            stage1_q <= mergeWord;
         end
         stage2_q <= stage1_q;
         rvld1_q  <= rdAcc;
         rvld2_q  <= rvld1_q;
      end
   end

   generate
      if (READ_LAT == 2) begin : gen_lat2
         assign Q    = stage2_q;
         assign RVLD = rvld2_q;
      end else begin : gen_lat1
         assign Q    = stage1_q;
         assign RVLD = rvld1_q;
      end
   endgenerate

   assign INIT_DONE = initDone;

endmodule

// File: tb/tb_ct_f_spsram_param.sv
// Randomised self-checking bench: two initialising instances (latency 1 and 2) share
// stimulus against an array model; a third instance without init has its own reset.
module tb_ct_f_spsram_param;

   localparam int AW    = 4;
   localparam int DW    = 32;
   localparam int WS    = 8;
   localparam int DEPTH = 16;
   localparam int LANES = DW / WS;

   logic          CLK;
   logic          RSTN;
   logic          RSTN3;
   logic          CEN;
   logic          GWEN;
   logic [AW-1:0] A;
   logic [DW-1:0] D;
   logic [DW-1:0] WEN;

   logic [DW-1:0] q1, q2, q3;
   logic          rvld1, rvld2, rvld3;
   logic          done1, done2, done3;

   int errors = 0;
   int checks = 0;

   ct_f_spsram_param #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .WRAP_SIZE(WS),
                       .READ_LAT(1), .INIT_EN(1'b1)) dut1 (
      .CLK(CLK), .RSTN(RSTN), .CEN(CEN), .GWEN(GWEN), .A(A), .D(D), .WEN(WEN),
      .Q(q1), .RVLD(rvld1), .INIT_DONE(done1));

   ct_f_spsram_param #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .WRAP_SIZE(WS),
                       .READ_LAT(2), .INIT_EN(1'b1)) dut2 (
      .CLK(CLK), .RSTN(RSTN), .CEN(CEN), .GWEN(GWEN), .A(A), .D(D), .WEN(WEN),
      .Q(q2), .RVLD(rvld2), .INIT_DONE(done2));

   ct_f_spsram_param #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .WRAP_SIZE(WS),
                       .READ_LAT(1), .INIT_EN(1'b0)) dut3 (
      .CLK(CLK), .RSTN(RSTN3), .CEN(CEN), .GWEN(GWEN), .A(A), .D(D), .WEN(WEN),
      .Q(q3), .RVLD(rvld3), .INIT_DONE(done3));

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   // Reference: plain array plus the word returned by the latest access and by the one before.
   logic [DW-1:0] refMem [DEPTH];
   bit            refReady;
   int            edgesSinceRst;
   logic [DW-1:0] s1Now, s1Prev;
   bit            rdNow, rdPrev;

   task automatic checkOutput(input string tag, input logic [DW-1:0] observed,
                              input logic [DW-1:0] expected);
      checks++;
      if (observed !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got %h expected %h at %0t", tag, observed, expected, $time);
      end
   endtask

   task automatic resetModel();
      refReady      = 1'b0;
      edgesSinceRst = 0;
      s1Now         = '0;
      s1Prev        = '0;
      rdNow         = 1'b0;
      rdPrev        = 1'b0;
   endtask

   task automatic checkAll(input string tag);
      checkOutput({tag, ":q1"},    q1,          s1Now);
      checkOutput({tag, ":rvld1"}, DW'(rvld1),  DW'(rdNow));
      checkOutput({tag, ":q2"},    q2,          s1Prev);
      checkOutput({tag, ":rvld2"}, DW'(rvld2),  DW'(rdPrev));
      checkOutput({tag, ":done1"}, DW'(done1),  DW'(refReady));
      checkOutput({tag, ":done2"}, DW'(done2),  DW'(refReady));
   endtask

   task automatic applyStimulus(input logic cen, input logic gwen, input logic [AW-1:0] a,
                                input logic [DW-1:0] d, input logic [DW-1:0] wen);
      CEN  = cen;
      GWEN = gwen;
      A    = a;
      D    = d;
      WEN  = wen;
      @(posedge CLK);
      s1Prev = s1Now;
      rdPrev = rdNow;
      rdNow  = 1'b0;
      if (refReady && !cen) begin
         if (!gwen) begin
            for (int k = 0; k < LANES; k++) begin
               if (!wen[k*WS + WS - 1]) refMem[a][k*WS +: WS] = d[k*WS +: WS];
            end
         end else begin
            rdNow = 1'b1;
         end
         s1Now = refMem[a];
      end
      edgesSinceRst++;
      if (!refReady && edgesSinceRst >= DEPTH) begin
         refReady = 1'b1;
         for (int i = 0; i < DEPTH; i++) refMem[i] = '0;
      end
      #1;
   endtask

   task automatic doReset();
      RSTN = 1'b0;
      CEN  = 1'b1;
      GWEN = 1'b1;
      resetModel();
      @(posedge CLK);
      #1;
      checkAll("rst");
      @(posedge CLK);
      @(negedge CLK);
      RSTN = 1'b1;
   endtask

   initial begin
      RSTN  = 1'b0;
      RSTN3 = 1'b0;
      CEN   = 1'b1;
      GWEN  = 1'b1;
      A     = '0;
      D     = '0;
      WEN   = '1;
      for (int i = 0; i < DEPTH; i++) refMem[i] = '0;

      doReset();
      checkOutput("rst:q3",    q3,         '0);
      checkOutput("rst:rvld3", DW'(rvld3), '0);
      checkOutput("rst:done3", DW'(done3), '0);

      // Writes during the init sweep must be ignored; done rises after the 16th edge.
      for (int i = 0; i < DEPTH; i++) begin
         applyStimulus(1'b0, 1'b0, 4'd3, 32'hFFFF_FFFF, 32'h0);
         checkAll("init");
      end
      for (int i = 0; i < DEPTH; i++) begin
         applyStimulus(1'b0, 1'b1, AW'(i), DW'($urandom), DW'($urandom));
         checkAll("zero");
      end

      // Lane mask: enable lanes 0 and 2 only.
      applyStimulus(1'b0, 1'b0, 4'd5, 32'hAABB_CCDD, 32'h0000_0000);
      checkAll("lane:w1");
      applyStimulus(1'b0, 1'b0, 4'd5, 32'h1122_3344, 32'hFF00_FF00);
      checkAll("lane:w2");
      checkOutput("lane:merge", q1, 32'hAA22_CC44);
      applyStimulus(1'b0, 1'b1, 4'd5, 32'h0, 32'hFFFF_FFFF);
      checkAll("lane:rd");

      // Read then idle: both latencies must hold their value.
      applyStimulus(1'b0, 1'b1, 4'd5, 32'h0, 32'hFFFF_FFFF);
      checkAll("hold:rd");
      for (int i = 0; i < 10; i++) begin
         applyStimulus(1'b1, 1'($urandom), AW'($urandom), DW'($urandom), DW'($urandom));
         checkAll("hold");
      end
      checkOutput("hold:q2", q2, 32'hAA22_CC44);

      for (int i = 0; i < 8; i++) begin
         applyStimulus(1'b0, i[0], 4'd9, 32'h1234_5678, 32'h0);
         checkAll("b2b");
      end

      for (int i = 0; i < 200; i++) begin
         applyStimulus(1'($urandom_range(0, 3) == 0), 1'($urandom), AW'($urandom),
                       DW'($urandom), ($urandom_range(0, 3) == 0) ? 32'h0 : DW'($urandom));
         checkAll("rand");
      end

      // Reset in the middle of the sweep: the sweep must restart from scratch.
      doReset();
      for (int i = 0; i < 7; i++) begin
         applyStimulus(1'($urandom), 1'($urandom), AW'($urandom), DW'($urandom), DW'($urandom));
         checkAll("mid");
      end
      RSTN = 1'b0;
      resetModel();
      #1;
      checkAll("mid:rst");
      @(posedge CLK);
      @(negedge CLK);
      RSTN = 1'b1;
      for (int i = 0; i < DEPTH + 4; i++) begin
         applyStimulus(1'($urandom), 1'($urandom), AW'($urandom), DW'($urandom), DW'($urandom));
         checkAll("mid:sweep");
      end
      for (int i = 0; i < 40; i++) begin
         applyStimulus(1'($urandom_range(0, 3) == 0), 1'($urandom), AW'($urandom),
                       DW'($urandom), DW'($urandom));
         checkAll("mid:rand");
      end

      // Instance without init: usable one edge after release.
      @(negedge CLK);
      RSTN3 = 1'b1;
      applyStimulus(1'b1, 1'b1, 4'd0, 32'h0, 32'hFFFF_FFFF);
      checkAll("i0");
      checkOutput("i0:done3",  DW'(done3), 32'd1);
      checkOutput("i0:rvld3a", DW'(rvld3), 32'd0);
      applyStimulus(1'b0, 1'b1, 4'd7, 32'h0, 32'hFFFF_FFFF);
      checkAll("i0");
      checkOutput("i0:rvld3b", DW'(rvld3), 32'd1);
      applyStimulus(1'b0, 1'b0, 4'd2, 32'hCAFE_F00D, 32'h0);
      checkAll("i0");
      checkOutput("i0:rvld3c", DW'(rvld3), 32'd0);
      checkOutput("i0:wq3",    q3,         32'hCAFE_F00D);
      applyStimulus(1'b0, 1'b1, 4'd2, 32'h0, 32'hFFFF_FFFF);
      checkAll("i0");
      checkOutput("i0:rq3",    q3,         32'hCAFE_F00D);
      checkOutput("i0:rvld3d", DW'(rvld3), 32'd1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
